recursive_mult_seq: RTL and testbench

Parametrised, multi-cycle W×W unsigned recursive multiplier that reuses a single 4×4 tile multiplier to build the full product one tile per cycle. Each operation selects exact, fully approximate or hybrid mode at issue time, so accuracy/power trade-offs are evaluated on one datapath. It sits behind a valid/ready producer and feeds a valid/ready consumer, for example an error-metric collector.

---
 rtl/recursive_mult_pkg.sv | 24 ++
 rtl/approx_tile_4x4.sv | 37 +++
 rtl/recursive_mult_seq.sv | 146 ++++++++++++++
 tb/tb_recursive_mult_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/recursive_mult_pkg.sv
// Shared definitions for the sequential recursive multiplier.
//   MODE_*       : per-operation accuracy mode encodings (2'b11 behaves as exact)
//   state_e      : controller states
//   tile_weight  : left-shift applied to tile (i,j) before accumulation
package recursive_mult_pkg;

  localparam logic [1:0] MODE_EXACT  = 2'b00;
  localparam logic [1:0] MODE_APPROX = 2'b01;
  localparam logic [1:0] MODE_HYBRID = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Tile (i,j) multiplies digit i of a by digit j of b, so it carries
  // weight 16^(i+j).
  function automatic int unsigned tile_weight(input int unsigned i,
                                              input int unsigned j);
    return 4 * (i + j);
  endfunction

endpackage

// File: rtl/approx_tile_4x4.sv
// 4x4 unsigned tile multiplier with an optional approximate mode.
//   x, y   : 4-bit operands
//   approx : 0 -> exact 8-bit product, 1 -> approximate product
//   prod   : 8-bit result
// The approximate product splits each operand into 2-bit halves and
// combines four 2x2 blocks exactly; only the 2x2 blocks are inexact
// (3x3 yields 7 so each block fits in 3 bits).
module approx_tile_4x4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       approx,
  output logic [7:0] prod
);

  function automatic logic [2:0] mul2(input logic [1:0] u,
                                      input logic [1:0] v);
    if (u == 2'd3 && v == 2'd3) return 3'd7;
    return {1'b0, u} * {1'b0, v};
  endfunction

  logic [2:0] hh, hl, lh, ll;
  logic [3:0] mid_sum;
  logic [7:0] approx_prod;
  logic [7:0] exact_prod;

  assign hh = mul2(x[3:2], y[3:2]);
  assign hl = mul2(x[3:2], y[1:0]);
  assign lh = mul2(x[1:0], y[3:2]);
  assign ll = mul2(x[1:0], y[1:0]);

  assign mid_sum     = {1'b0, hl} + {1'b0, lh};
  assign approx_prod = {1'b0, hh, 4'b0000} + {2'b00, mid_sum, 2'b00} + {5'b00000, ll};
  assign exact_prod  = {4'b0000, x} * {4'b0000, y};

  assign prod = approx ? approx_prod : exact_prod;

endmodule

// File: rtl/recursive_mult_seq.sv
// Multi-cycle WxW unsigned multiplier built from one reused 4x4 tile.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (a, b, mode captured on accept)
//   out_valid / out_ready : product handshake (p held stable while out_valid)
//   p                     : 2W-bit product, holds last result between operations
//   busy                  : high while an operation is in RUN or DONE
//   dbg_state_o           : current controller state (recursive_mult_pkg::state_e)
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends combinationally on ready, and every output
// is a register or a decode of the state register.
// W must be a multiple of 4 and at least 4.
module recursive_mult_seq
  import recursive_mult_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [1:0]     mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy,
  output logic [1:0]     dbg_state_o
);

  localparam int K  = W / 4;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = 2 * W;
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]    mode_q, mode_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] p_q, p_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d;

  logic [3:0]    dig_a, dig_b;
  logic          tile_approx;
  logic [7:0]    tile_prod;
  logic [PW-1:0] tile_shifted;
  logic [PW-1:0] acc_sum;
  logic [IW:0]   idx_sum;
  logic          last_tile;

  // Digit select: i walks a, j walks b.
  assign dig_a = a_q[{i_q, 2'b00} +: 4];
  assign dig_b = b_q[{j_q, 2'b00} +: 4];

  // Hybrid keeps the low-weight tiles (i+j < K) approximate.
  assign idx_sum = {1'b0, i_q} + {1'b0, j_q};

  always_comb begin
    case (mode_q)
      MODE_APPROX: tile_approx = 1'b1;
      MODE_HYBRID: tile_approx = (idx_sum < (IW+1)'(K));
      default:     tile_approx = 1'b0;
    endcase
  end

  approx_tile_4x4 u_tile (
    .x      (dig_a),
    .y      (dig_b),
    .approx (tile_approx),
    .prod   (tile_prod)
  );

  assign tile_shifted = PW'(tile_prod) << tile_weight(32'(i_q), 32'(j_q));
  assign acc_sum      = acc_q + tile_shifted;
  assign last_tile    = (i_q == LAST) && (j_q == LAST);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    p_d     = p_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_sum;
        if (last_tile) begin
          // p is only ever written with a complete product.
          p_d     = acc_sum;
          state_d = ST_DONE;
        end else if (j_q == LAST) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= MODE_EXACT;
      acc_q   <= '0;
      p_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign p           = p_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_recursive_mult_seq.sv
module tb_recursive_mult_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // W=8 instance
  logic        in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [1:0]  mode8 = '0;
  logic        in_ready8, out_valid8, busy8;
  logic [15:0] p8;
  logic [1:0]  dbg8;

  // W=4 instance
  logic        in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [1:0]  mode4 = '0;
  logic        in_ready4, out_valid4, busy4;
  logic [7:0]  p4;
  logic [1:0]  dbg4;

  // W=16 instance
  logic        in_valid16 = 1'b0, out_ready16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [1:0]  mode16 = '0;
  logic        in_ready16, out_valid16, busy16;
  logic [31:0] p16;
  logic [1:0]  dbg16;

  recursive_mult_seq #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .mode(mode8), .out_valid(out_valid8), .out_ready(out_ready8),
    .p(p8), .busy(busy8), .dbg_state_o(dbg8));

  recursive_mult_seq #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .mode(mode4), .out_valid(out_valid4), .out_ready(out_ready4),
    .p(p4), .busy(busy4), .dbg_state_o(dbg4));

  recursive_mult_seq #(.W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .mode(mode16), .out_valid(out_valid16), .out_ready(out_ready16),
    .p(p16), .busy(busy16), .dbg_state_o(dbg16));

  // ---------------- reference model ----------------
  function automatic longint unsigned blk2(input longint unsigned x, input longint unsigned y);
    return (x == 3 && y == 3) ? 64'd7 : x * y;
  endfunction

  function automatic longint unsigned tile_ref(input longint unsigned x, input longint unsigned y,
                                               input bit approx);
    if (!approx) return x * y;
    return (blk2(x / 4, y / 4) * 16) + ((blk2(x / 4, y % 4) + blk2(x % 4, y / 4)) * 4)
           + blk2(x % 4, y % 4);
  endfunction

  function automatic longint unsigned ref_mult(input longint unsigned x, input longint unsigned y,
                                               input int unsigned md, input int k);
    longint unsigned sum = 0;
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < k; j++) begin
        bit ap;
        longint unsigned dx, dy, wt;
        ap = (md == 1) || (md == 2 && (i + j) < k);
        dx = (x >> (4 * i)) % 16;
        dy = (y >> (4 * j)) % 16;
        wt = 64'd1 << (4 * (i + j));
        sum += tile_ref(dx, dy, ap) * wt;
      end
    end
    return sum;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic op8(input logic [7:0] aa, input logic [7:0] bb, input logic [1:0] mm,
                     output logic [15:0] res, output int lat);
    @(negedge clk);
    a8 = aa; b8 = bb; mode8 = mm; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 200) begin @(negedge clk); lat++; end
    res = p8;
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
  endtask

  task automatic op4(input logic [3:0] aa, input logic [3:0] bb, input logic [1:0] mm,
                     output logic [7:0] res, output int lat);
    @(negedge clk);
    a4 = aa; b4 = bb; mode4 = mm; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 200) begin @(negedge clk); lat++; end
    res = p4;
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
  endtask

  task automatic op16(input logic [15:0] aa, input logic [15:0] bb, input logic [1:0] mm,
                      output logic [31:0] res, output int lat);
    @(negedge clk);
    a16 = aa; b16 = bb; mode16 = mm; in_valid16 = 1'b1;
    @(negedge clk);
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 400) begin @(negedge clk); lat++; end
    res = p16;
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clk);
    checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready8); end
    checks++; if (out_valid8 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid8); end
    checks++; if (p8 !== 16'd0) begin failures++; $display("FAIL reset_p got=%0d exp=0", p8); end
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    checks++; if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || p16 !== 32'd0) begin
      failures++; $display("FAIL reset_w16 in_ready=%b out_valid=%b p=%0d exp 1/0/0", in_ready16, out_valid16, p16);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_corners8;
    logic [7:0]  ta[6] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd0,   8'd128};
    logic [7:0]  tb_[6] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd200, 8'd1};
    logic [1:0]  tm[6] = '{2'd0,   2'd1,   2'd2,   2'd3,   2'd2,   2'd1};
    logic [15:0] te[6] = '{16'd65025, 16'd50575, 16'd63375, 16'd65025, 16'd0, 16'd128};
    logic [15:0] res;
    int lat;
    for (int n = 0; n < 6; n++) begin
      op8(ta[n], tb_[n], tm[n], res, lat);
      checks++; if (res !== te[n]) begin failures++; $display("FAIL corner8_p[%0d] got=%0d exp=%0d", n, res, te[n]); end
      checks++; if (lat != 4) begin failures++; $display("FAIL corner8_latency[%0d] got=%0d exp=4", n, lat); end
    end
  endtask

  task automatic test_random8;
    logic [15:0] res, exp;
    logic [7:0]  x, y;
    logic [1:0]  m;
    int lat;
    for (int n = 0; n < 24; n++) begin
      x = 8'($urandom); y = 8'($urandom); m = 2'($urandom_range(0, 3));
      exp = 16'(ref_mult(64'(x), 64'(y), 32'(m), 2));
      op8(x, y, m, res, lat);
      checks++; if (res !== exp) begin
        failures++; $display("FAIL random8 a=%0d b=%0d mode=%0d got=%0d exp=%0d", x, y, m, res, exp);
      end
    end
  endtask

  task automatic test_sweep4;
    logic [7:0] res, exp;
    int lat;
    bit has33, differs;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        op4(4'(x), 4'(y), 2'd0, res, lat);
        exp = 8'(x * y);
        checks++; if (res !== exp) begin failures++; $display("FAIL sweep4_exact %0dx%0d got=%0d exp=%0d", x, y, res, exp); end
        checks++; if (lat != 1) begin failures++; $display("FAIL sweep4_latency %0dx%0d got=%0d exp=1", x, y, lat); end
        op4(4'(x), 4'(y), 2'd1, res, lat);
        exp = 8'(ref_mult(64'(x), 64'(y), 1, 1));
        checks++; if (res !== exp) begin failures++; $display("FAIL sweep4_approx %0dx%0d got=%0d exp=%0d", x, y, res, exp); end
        has33 = ((x / 4 == 3) || (x % 4 == 3)) && ((y / 4 == 3) || (y % 4 == 3));
        differs = (res != 8'(x * y));
        checks++; if (differs != has33) begin
          failures++; $display("FAIL sweep4_error_site %0dx%0d got_differs=%0d exp_differs=%0d", x, y, differs, has33);
        end
      end
    end
    op4(4'd15, 4'd15, 2'd1, res, lat);
    checks++; if (res !== 8'd175) begin failures++; $display("FAIL sweep4_15x15 got=%0d exp=175", res); end
  endtask

  task automatic test_backpressure;
    logic [15:0] exp, res;
    int lat;
    exp = 16'(ref_mult(64'hA5, 64'h3C, 2, 2));
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h3C; mode8 = 2'd2; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 200) begin @(negedge clk); lat++; end
    checks++; if (p8 !== exp) begin failures++; $display("FAIL bp_p got=%0d exp=%0d", p8, exp); end
    // A competing request while the result waits must be ignored.
    a8 = 8'h11; b8 = 8'h22; mode8 = 2'd0; in_valid8 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (out_valid8 !== 1'b1 || p8 !== exp || in_ready8 !== 1'b0 || busy8 !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d] out_valid=%b p=%0d in_ready=%b busy=%b exp 1/%0d/0/1", c, out_valid8, p8, in_ready8, busy8, exp);
      end
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    checks++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
      failures++; $display("FAIL bp_release out_valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid8, in_ready8, busy8);
    end
    checks++; if (p8 !== exp) begin failures++; $display("FAIL bp_p_held_idle got=%0d exp=%0d", p8, exp); end
    op8(8'd17, 8'd34, 2'd0, res, lat);
    checks++; if (res !== 16'd578) begin failures++; $display("FAIL bp_next_op got=%0d exp=578", res); end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] res;
    int lat;
    op16(16'd60000, 16'd60001, 2'd0, res, lat);
    checks++; if (res !== 32'd3600060000) begin failures++; $display("FAIL w16_pre got=%0d exp=3600060000", res); end
    checks++; if (lat != 16) begin failures++; $display("FAIL w16_latency got=%0d exp=16", lat); end
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'hFFFF; mode16 = 2'd1; in_valid16 = 1'b1;
    @(negedge clk);                 // accepted, tile 0 in progress
    in_valid16 = 1'b0;
    @(negedge clk);                 // tile 1
    @(negedge clk);                 // tile 2 (third tile)
    checks++; if (busy16 !== 1'b1) begin failures++; $display("FAIL w16_busy_mid_run got=%b exp=1", busy16); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid16 !== 1'b0 || p16 !== 32'd0 || in_ready16 !== 1'b1 || busy16 !== 1'b0) begin
      failures++;
      $display("FAIL w16_async_reset out_valid=%b p=%0d in_ready=%b busy=%b exp 0/0/1/0", out_valid16, p16, in_ready16, busy16);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    op16(16'd1234, 16'd4321, 2'd0, res, lat);
    checks++; if (res !== 32'd5332114) begin failures++; $display("FAIL w16_after_reset got=%0d exp=5332114", res); end
    checks++; if (lat != 16) begin failures++; $display("FAIL w16_after_reset_latency got=%0d exp=16", lat); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_q[$];
    logic [15:0] exp;
    int n_acc = 0;
    int n_res = 0;
    int last_res = -1;
    int cyc = 0;
    bit acc_prev = 1'b0;
    @(negedge clk);
    out_ready8 = 1'b1;
    in_valid8 = 1'b1;
    a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 2'($urandom_range(0, 3));
    while (n_res < 12 && cyc < 400) begin
      if (acc_prev) begin
        if (n_acc < 12) begin
          a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 2'($urandom_range(0, 3));
        end else begin
          in_valid8 = 1'b0;
        end
        acc_prev = 1'b0;
      end
      if (out_valid8) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_unexpected_result got=%0d", p8);
        end else begin
          exp = exp_q.pop_front();
          if (p8 !== exp) begin failures++; $display("FAIL b2b_p[%0d] got=%0d exp=%0d", n_res, p8, exp); end
        end
        if (last_res >= 0) begin
          checks++; if (cyc - last_res != 6) begin
            failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp=6", n_res, cyc - last_res);
          end
        end
        last_res = cyc;
        n_res++;
      end
      checks++; if (in_ready8 && out_valid8) begin failures++; $display("FAIL b2b_overlap in_ready=1 out_valid=1 exp not both"); end
      if (in_ready8 && in_valid8) begin
        exp_q.push_back(16'(ref_mult(64'(a8), 64'(b8), 32'(mode8), 2)));
        n_acc++;
        acc_prev = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    checks++; if (n_res != 12) begin failures++; $display("FAIL b2b_count got=%0d exp=12", n_res); end
    in_valid8 = 1'b0;
    out_ready8 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_corners8();
    test_random8();
    test_sweep4();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
